// File: rtl/cart_pkg.sv
// Shared constants and helpers for the cartridge bank-switching mapper.
package cart_pkg;

    // Raw scheme_i encodings as driven by the loader.
    localparam logic [2:0] SCHEME_4K = 3'd0;
    localparam logic [2:0] SCHEME_F8 = 3'd1;
    localparam logic [2:0] SCHEME_F6 = 3'd2;
    localparam logic [2:0] SCHEME_F4 = 3'd3;
    localparam logic [2:0] SCHEME_E0 = 3'd4;
    localparam logic [2:0] SCHEME_3F = 3'd5;

    // Decoded scheme; unused encodings fold onto plain 4K.
    typedef enum logic [2:0] {
        MAP_4K,
        MAP_F8,
        MAP_F6,
        MAP_F4,
        MAP_E0,
        MAP_3F
    } map_e;

    // First hotspot address of each scheme.
    localparam logic [12:0] HS_F8_BASE = 13'h1FF8;
    localparam logic [12:0] HS_F6_BASE = 13'h1FF6;
    localparam logic [12:0] HS_F4_BASE = 13'h1FF4;
    localparam logic [12:0] HS_E0_BASE = 13'h1FE0;

    // Number of hotspots per scheme (E0 covers three 8-address slices).
    localparam logic [12:0] HS_F8_CNT = 13'd2;
    localparam logic [12:0] HS_F6_CNT = 13'd4;
    localparam logic [12:0] HS_F4_CNT = 13'd8;
    localparam logic [12:0] HS_E0_CNT = 13'd24;

    // Superchip windows: A12..A7 select the 128-byte write or read page.
    localparam logic [5:0] SC_WR_PAGE = 6'b100000;   // $1000-$107F
    localparam logic [5:0] SC_RD_PAGE = 6'b100001;   // $1080-$10FF

    // Reset bank state. The F-scheme bank register resets to all ones so
    // that, once masked to the active scheme's width, it always points at
    // the last bank (F8 -> 1, F6 -> 3, F4 -> 7).
    localparam logic [2:0] RST_BANK    = 3'd7;
    localparam logic [2:0] RST_SLICE0  = 3'd4;
    localparam logic [2:0] RST_SLICE1  = 3'd5;
    localparam logic [2:0] RST_SLICE2  = 3'd6;
    localparam logic [3:0] RST_BANK3F  = 4'd0;
    localparam logic [2:0] E0_FIXED_SLICE3 = 3'd7;

    function automatic map_e decode_scheme(input logic [2:0] s);
        map_e m;
        case (s)
            SCHEME_F8: m = MAP_F8;
            SCHEME_F6: m = MAP_F6;
            SCHEME_F4: m = MAP_F4;
            SCHEME_E0: m = MAP_E0;
            SCHEME_3F: m = MAP_3F;
            default:   m = MAP_4K;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cart_sc_ram.sv
// Superchip RAM: single-port 8-bit synchronous RAM with a registered read.
module cart_sc_ram
    import cart_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic [AW-1:0] adr_i,
    input  logic          we_i,
    input  logic [7:0]    dat_i,
    input  logic          re_i,
    output logic [7:0]    dat_o
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_dat;

    // Memory array has no reset so contents survive reset and cart reloads.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[adr_i] <= dat_i;
        end
    end

    // Read data register; cleared on reset/reload, otherwise follows reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dat <= 8'h00;
        end else if (clr_i) begin
            r_dat <= 8'h00;
        end else if (re_i) begin
            r_dat <= r_mem[adr_i];
        end
    end

    assign dat_o = r_dat;

endmodule

// File: rtl/cart_mapper.sv
// Cartridge bank-switching mapper: 6507 address -> cartridge ROM address,
// bank state updated only on strobed CPU bus cycles, optional Superchip RAM.
module cart_mapper
    import cart_pkg::*;
#(
    parameter int ROM_AW   = 15,
    parameter int SC_DEPTH = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_ena_i,
    input  logic [12:0]       adr_i,
    input  logic              we_i,
    input  logic [7:0]        dat_i,
    input  logic [2:0]        scheme_i,
    input  logic              sc_en_i,
    input  logic              cart_load_i,
    output logic [ROM_AW-1:0] rom_adr_o,
    output logic              sc_sel_o,
    output logic [7:0]        sc_dat_o,
    output logic [2:0]        bank_o
);

    localparam int SC_AW = $clog2(SC_DEPTH);

    map_e        w_map;
    logic        w_f_scheme;
    logic        w_sc_wr;
    logic        w_sc_rd;
    logic [12:0] w_off_f8;
    logic [12:0] w_off_f6;
    logic [12:0] w_off_f4;
    logic [12:0] w_off_e0;
    logic        w_hs_hit;
    logic [2:0]  w_hs_bank;
    logic        w_hs_e0;
    logic        w_hs_3f;
    logic [2:0]  w_bank_eff;
    logic [2:0]  w_e0_bank;
    logic [14:0] w_rom_full;

    logic [2:0]  r_bank;
    logic [2:0]  r_slice0;
    logic [2:0]  r_slice1;
    logic [2:0]  r_slice2;
    logic [3:0]  r_bank3f;

    assign w_map      = decode_scheme(scheme_i);
    assign w_f_scheme = (w_map == MAP_F8) || (w_map == MAP_F6) || (w_map == MAP_F4);

    // Superchip only exists on F-schemes; write page is write-only, read page read-only.
    assign w_sc_wr  = sc_en_i && w_f_scheme && cpu_ena_i && we_i
                      && (adr_i[12:7] == SC_WR_PAGE);
    assign w_sc_rd  = sc_en_i && w_f_scheme && !we_i
                      && (adr_i[12:7] == SC_RD_PAGE);
    assign sc_sel_o = w_sc_rd;

    // Offsets from each hotspot base; addresses below a base wrap to large
    // values, so a single "less than count" test bounds both ends.
    assign w_off_f8 = adr_i - HS_F8_BASE;
    assign w_off_f6 = adr_i - HS_F6_BASE;
    assign w_off_f4 = adr_i - HS_F4_BASE;
    assign w_off_e0 = adr_i - HS_E0_BASE;

    // Hotspot decode for the active scheme: hit flag and the bank it selects.
    always_comb begin
        w_hs_hit  = 1'b0;
        w_hs_bank = 3'd0;
        w_hs_e0   = 1'b0;
        w_hs_3f   = 1'b0;
        case (w_map)
            MAP_F8: begin
                w_hs_hit  = (w_off_f8 < HS_F8_CNT);
                w_hs_bank = w_off_f8[2:0];
            end
            MAP_F6: begin
                w_hs_hit  = (w_off_f6 < HS_F6_CNT);
                w_hs_bank = w_off_f6[2:0];
            end
            MAP_F4: begin
                w_hs_hit  = (w_off_f4 < HS_F4_CNT);
                w_hs_bank = w_off_f4[2:0];
            end
            MAP_E0: begin
                w_hs_e0   = (w_off_e0 < HS_E0_CNT);
                w_hs_bank = adr_i[2:0];
            end
            MAP_3F: begin
                // TIA-range write ($00-$3F) latches the bank; TIA still sees it.
                w_hs_3f   = we_i && (adr_i[12:6] == 7'd0);
            end
            default: begin
                w_hs_hit  = 1'b0;
            end
        endcase
    end

    // Bank state: only strobed bus cycles touch it; reload restores defaults.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bank   <= RST_BANK;
            r_slice0 <= RST_SLICE0;
            r_slice1 <= RST_SLICE1;
            r_slice2 <= RST_SLICE2;
            r_bank3f <= RST_BANK3F;
        end else if (cart_load_i) begin
            r_bank   <= RST_BANK;
            r_slice0 <= RST_SLICE0;
            r_slice1 <= RST_SLICE1;
            r_slice2 <= RST_SLICE2;
            r_bank3f <= RST_BANK3F;
        end else if (cpu_ena_i) begin
            if (w_hs_hit) begin
                r_bank <= w_hs_bank;
            end
            if (w_hs_e0) begin
                case (w_off_e0[4:3])
                    2'd0:    r_slice0 <= w_hs_bank;
                    2'd1:    r_slice1 <= w_hs_bank;
                    default: r_slice2 <= w_hs_bank;
                endcase
            end
            if (w_hs_3f) begin
                r_bank3f <= dat_i[3:0];
            end
        end
    end

    // F-scheme bank masked to the active scheme's bank count.
    always_comb begin
        case (w_map)
            MAP_F8:  w_bank_eff = {2'b00, r_bank[0]};
            MAP_F6:  w_bank_eff = {1'b0, r_bank[1:0]};
            MAP_F4:  w_bank_eff = r_bank;
            default: w_bank_eff = 3'd0;
        endcase
    end

    // E0 1 KB slice bank for the current address; slice 3 is hardwired.
    always_comb begin
        case (adr_i[11:10])
            2'd0:    w_e0_bank = r_slice0;
            2'd1:    w_e0_bank = r_slice1;
            2'd2:    w_e0_bank = r_slice2;
            default: w_e0_bank = E0_FIXED_SLICE3;
        endcase
    end

    // ROM address translation and diagnostic bank output.
    always_comb begin
        w_rom_full = {3'b000, adr_i[11:0]};
        bank_o     = 3'd0;
        case (w_map)
            MAP_F8, MAP_F6, MAP_F4: begin
                w_rom_full = {w_bank_eff, adr_i[11:0]};
                bank_o     = w_bank_eff;
            end
            MAP_E0: begin
                w_rom_full = {2'b00, w_e0_bank, adr_i[9:0]};
                bank_o     = r_slice0;
            end
            MAP_3F: begin
                w_rom_full = adr_i[11] ? {4'hF, adr_i[10:0]} : {r_bank3f, adr_i[10:0]};
                bank_o     = r_bank3f[2:0];
            end
            default: begin
                w_rom_full = {3'b000, adr_i[11:0]};
                bank_o     = 3'd0;
            end
        endcase
    end

    assign rom_adr_o = w_rom_full[ROM_AW-1:0];

    cart_sc_ram #(
        .DEPTH (SC_DEPTH),
        .AW    (SC_AW)
    ) u_sc_ram (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cart_load_i),
        .adr_i (adr_i[SC_AW-1:0]),
        .we_i  (w_sc_wr),
        .dat_i (dat_i),
        .re_i  (w_sc_rd),
        .dat_o (sc_dat_o)
    );

endmodule

// File: tb/tb_cart_mapper.sv
// Directed bench for cart_mapper with an expected-value scoreboard queue.
module tb_cart_mapper;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ena;
    logic [12:0] adr;
    logic        we;
    logic [7:0]  dat;
    logic [2:0]  scheme;
    logic        sc_en;
    logic        cart_load;
    logic [14:0] rom_adr;
    logic        sc_sel;
    logic [7:0]  sc_dat;
    logic [2:0]  bank;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    cart_mapper #(.ROM_AW(15), .SC_DEPTH(128)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_ena_i   (cpu_ena),
        .adr_i       (adr),
        .we_i        (we),
        .dat_i       (dat),
        .scheme_i    (scheme),
        .sc_en_i     (sc_en),
        .cart_load_i (cart_load),
        .rom_adr_o   (rom_adr),
        .sc_sel_o    (sc_sel),
        .sc_dat_o    (sc_dat),
        .bank_o      (bank)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [15:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %h want <none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: got %h want %h", e.tag, obs, e.val);
            end
            $display("check %-14s got %h want %h", e.tag, obs, e.val);
        end
    endtask

    // Drive one bus cycle at the falling edge; outputs settle before the rising edge.
    task automatic cyc(input logic [12:0] a, input logic w, input logic [7:0] d, input logic e);
        @(negedge clk);
        adr = a; we = w; dat = d; cpu_ena = e;
        #1;
    endtask

    task automatic load(input logic [2:0] s);
        @(negedge clk);
        scheme = s; cart_load = 1'b1; cpu_ena = 1'b0;
        @(negedge clk);
        cart_load = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; cpu_ena = 1'b0; adr = 13'h1000; we = 1'b0; dat = 8'h00;
        scheme = 3'd1; sc_en = 1'b0; cart_load = 1'b0;
        #1;
        // Reset state, F8
        expect_val("rst_bank",   16'd1);    chk({13'd0, bank});
        expect_val("rst_sc_sel", 16'd0);    chk({15'd0, sc_sel});
        expect_val("rst_sc_dat", 16'd0);    chk({8'd0, sc_dat});
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // F8 switching
        cyc(13'h1000, 1'b0, 8'h00, 1'b0); expect_val("f8_1000",  16'h1000); chk({1'b0, rom_adr});
        cyc(13'h1FF8, 1'b0, 8'h00, 1'b1); expect_val("f8_hs_old", 16'h1FF8); chk({1'b0, rom_adr});
        cyc(13'h1000, 1'b0, 8'h00, 1'b0); expect_val("f8_b0",    16'h0000); chk({1'b0, rom_adr});
        expect_val("f8_bank0", 16'd0); chk({13'd0, bank});
        cyc(13'h1FF9, 1'b0, 8'h00, 1'b1); expect_val("f8_hs9_old", 16'h0FF9); chk({1'b0, rom_adr});
        cyc(13'h1000, 1'b0, 8'h00, 1'b0); expect_val("f8_b1",    16'h1000); chk({1'b0, rom_adr});

        // F4: unstrobed hotspot holds, strobed one switches
        load(3'd3);
        expect_val("f4_load_bank", 16'd7); chk({13'd0, bank});
        repeat (50) cyc(13'h1FF6, 1'b0, 8'h00, 1'b0);
        expect_val("f4_nostrobe", 16'd7); chk({13'd0, bank});
        cyc(13'h1FF6, 1'b0, 8'h00, 1'b1);
        cyc(13'h1ABC, 1'b0, 8'h00, 1'b0);
        expect_val("f4_bank2",  16'd2);     chk({13'd0, bank});
        expect_val("f4_1abc",   16'h2ABC);  chk({1'b0, rom_adr});
        cyc(13'h1FFB, 1'b0, 8'h00, 1'b1);
        cyc(13'h1000, 1'b0, 8'h00, 1'b0); expect_val("f4_top7", 16'h7000); chk({1'b0, rom_adr});
        cyc(13'h1FF4, 1'b1, 8'hAA, 1'b1);
        cyc(13'h1000, 1'b0, 8'h00, 1'b0); expect_val("f4_wr_b0", 16'h0000); chk({1'b0, rom_adr});
        cyc(13'h1FFC, 1'b0, 8'h00, 1'b1);
        cyc(13'h1000, 1'b0, 8'h00, 1'b0); expect_val("f4_1ffc_nohs", 16'h0000); chk({1'b0, rom_adr});

        // F6 with Superchip
        sc_en = 1'b1;
        load(3'd2);
        expect_val("f6_load_bank", 16'd3); chk({13'd0, bank});
        cyc(13'h1012, 1'b1, 8'h55, 1'b1);
        cyc(13'h107F, 1'b1, 8'h3C, 1'b1);
        cyc(13'h1092, 1'b1, 8'hAA, 1'b1);   // write to read port: ignored
        cyc(13'h1092, 1'b0, 8'h00, 1'b1);
        expect_val("sc_sel_rd", 16'd1); chk({15'd0, sc_sel});
        @(posedge clk); #1;
        expect_val("sc_dat_55", 16'h0055); chk({8'd0, sc_dat});
        cyc(13'h10FF, 1'b0, 8'h00, 1'b1);
        @(posedge clk); #1;
        expect_val("sc_dat_3c", 16'h003C); chk({8'd0, sc_dat});
        cyc(13'h1012, 1'b0, 8'h00, 1'b0);
        expect_val("sc_sel_wrport", 16'd0);    chk({15'd0, sc_sel});
        expect_val("f6_1012_rom",   16'h3012); chk({1'b0, rom_adr});
        cyc(13'h1FF7, 1'b0, 8'h00, 1'b1);
        cyc(13'h1000, 1'b0, 8'h00, 1'b0); expect_val("f6_b1", 16'h1000); chk({1'b0, rom_adr});
        sc_en = 1'b0;
        cyc(13'h1092, 1'b0, 8'h00, 1'b0); expect_val("sc_off_sel", 16'd0); chk({15'd0, sc_sel});
        sc_en = 1'b1;

        // E0 slices
        load(3'd4);
        expect_val("e0_load_bank", 16'd4); chk({13'd0, bank});
        cyc(13'h1FE3, 1'b0, 8'h00, 1'b1);
        cyc(13'h1FEA, 1'b0, 8'h00, 1'b1);
        cyc(13'h1FF1, 1'b0, 8'h00, 1'b1);
        cyc(13'h1000, 1'b0, 8'h00, 1'b0); expect_val("e0_s0", 16'h0C00); chk({1'b0, rom_adr});
        cyc(13'h1400, 1'b0, 8'h00, 1'b0); expect_val("e0_s1", 16'h0800); chk({1'b0, rom_adr});
        cyc(13'h1800, 1'b0, 8'h00, 1'b0); expect_val("e0_s2", 16'h0400); chk({1'b0, rom_adr});
        cyc(13'h1C00, 1'b0, 8'h00, 1'b0); expect_val("e0_s3", 16'h1C00); chk({1'b0, rom_adr});
        cyc(13'h1092, 1'b0, 8'h00, 1'b0); expect_val("e0_no_sc", 16'd0); chk({15'd0, sc_sel});
        expect_val("e0_bank_o", 16'd3); chk({13'd0, bank});

        // 3F
        load(3'd5);
        expect_val("3f_load_bank", 16'd0); chk({13'd0, bank});
        cyc(13'h003F, 1'b1, 8'h03, 1'b1);
        cyc(13'h1000, 1'b0, 8'h00, 1'b0); expect_val("3f_b3", 16'h1800); chk({1'b0, rom_adr});
        cyc(13'h003F, 1'b0, 8'h07, 1'b1);
        cyc(13'h1000, 1'b0, 8'h00, 1'b0); expect_val("3f_rd_nochg", 16'h1800); chk({1'b0, rom_adr});
        cyc(13'h0040, 1'b1, 8'h05, 1'b1);
        cyc(13'h1000, 1'b0, 8'h00, 1'b0); expect_val("3f_0040_nochg", 16'h1800); chk({1'b0, rom_adr});
        cyc(13'h1800, 1'b0, 8'h00, 1'b0); expect_val("3f_last2k", 16'h7800); chk({1'b0, rom_adr});

        // Asynchronous reset mid-run (F6 with SC)
        load(3'd2);
        cyc(13'h1FF6, 1'b0, 8'h00, 1'b1);
        cyc(13'h1092, 1'b0, 8'h00, 1'b1);
        @(posedge clk); #1;
        expect_val("pre_rst_bank", 16'd0);     chk({13'd0, bank});
        expect_val("pre_rst_sc",   16'h0055);  chk({8'd0, sc_dat});
        cpu_ena = 1'b0; adr = 13'h1FF6;
        #2;
        rst = 1'b1; cart_load = 1'b1;
        #1;
        expect_val("async_rst_bank", 16'd3); chk({13'd0, bank});
        expect_val("async_rst_sc",   16'd0); chk({8'd0, sc_dat});
        cpu_ena = 1'b1;
        @(posedge clk); #1;
        expect_val("rst_hold_bank", 16'd3); chk({13'd0, bank});
        @(negedge clk);
        rst = 1'b0; cart_load = 1'b0;
        cyc(13'h1092, 1'b0, 8'h00, 1'b1);
        @(posedge clk); #1;
        expect_val("sc_retained", 16'h0055); chk({8'd0, sc_dat});
        cyc(13'h1000, 1'b0, 8'h00, 1'b0);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
